// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-step shift-add multiplier / restoring divider with HI/LO registers
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div_by_zero_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, next_state;
  logic [2*W-1:0] acc, step, prod;
  logic [W-1:0]   opnd, mag_a, mag_b, fix_hi, fix_lo;
  logic [W:0]     mul_sum, div_top, div_diff;
  logic [CW-1:0]  cnt;
  logic           is_div, neg_q, neg_r, dz;
  logic           is_md, sgn, op_div, accept;
  assign is_md  = alu_operation_i inside {4'b1010, 4'b1011, 4'b1100, 4'b1101};
  assign op_div = alu_operation_i[2];
  assign sgn    = ~alu_operation_i[0];
  assign accept = (state == IDLE) && start_i && is_md;
  assign mag_a  = (sgn && a_i[W-1]) ? -a_i : a_i;
  assign mag_b  = (sgn && b_i[W-1]) ? -b_i : b_i;
  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
  assign div_top  = acc[2*W-1:W-1];
  assign div_diff = div_top - {1'b0, opnd};
  assign step = is_div ? (div_diff[W] ? {div_top[W-1:0], acc[W-2:0], 1'b0}
                                      : {div_diff[W-1:0], acc[W-2:0], 1'b1})
                       : {mul_sum, acc[W-1:1]};
  assign prod   = neg_q ? -acc : acc;
  assign fix_hi = is_div ? (neg_r ? -acc[2*W-1:W] : acc[2*W-1:W]) : prod[2*W-1:W];
  assign fix_lo = is_div ? (neg_q ? -acc[W-1:0] : acc[W-1:0]) : prod[W-1:0];
  assign busy_o        = state != IDLE;
  assign done_o        = state == DONE;
  assign div_by_zero_o = (state == DONE) && dz;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: next_state = accept ? ((op_div && b_i == '0) ? DONE : RUN) : IDLE;
      RUN:  next_state = (cnt == CW'(W - 1)) ? FIX : RUN;
      FIX:  next_state = DONE;
      DONE: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else if (accept) begin
      acc    <= {{W{1'b0}}, op_div ? mag_a : mag_b};
      opnd   <= op_div ? mag_b : mag_a;
      cnt    <= '0;
      is_div <= op_div;
      neg_q  <= sgn && (a_i[W-1] ^ b_i[W-1]);
      neg_r  <= sgn && a_i[W-1];
      dz     <= op_div && (b_i == '0);
    end else if (state == RUN) begin
      acc <= step;
      cnt <= cnt + 1'b1;
    end else if (state == FIX) begin
      hi_o <= fix_hi;
      lo_o <= fix_lo;
    end
  end
endmodule
